frame_accumulator: RTL and testbench
====================================

Name: frame_accumulator

Overview:
- Parametrised multi-channel frame accumulator. It drains NUM_CH host-to-FPGA FIFOs in round-robin, FRAME_LEN words per channel, and sums signed integer words in a local accumulator.
- Writes sums to the FPGA-to-host FIFO, either one sum per channel frame or one combined sum over all channels, selected at run time.
- Sits between the host FIFOs and the host return FIFO.
- Next generation of the two-FIFO accumulator controller: arbitrary channel count, frame length and width, no external adder IP.

Parameters:
- NUM_CH, 2, number of input FIFOs/channels (>=1).
- DATA_W, 32, input word width, signed two's complement.
- FRAME_LEN, 128, words consumed per channel per frame (>=1).
- ACC_W, 48, accumulator and output width (ACC_W >= DATA_W).

Ports:
- bus_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_empty  in  NUM_CH  per-channel FIFO empty flag.
- in_rden  out  NUM_CH  per-channel pop, one-hot or zero.
- in_dout  in  NUM_CH*DATA_W  FWFT data; channel k occupies bits [k*DATA_W +: DATA_W].
- out_full  in  1  output FIFO full.
- out_wren  out  1  output FIFO write strobe.
- out_din  out  ACC_W  sum being written.
- per_ch_mode  in  1  1 = emit per-channel sums, 0 = emit combined sum.
- busy  out  1  high whenever a frame is partially accumulated or awaiting write.
- frames_done  out  16  count of results written; wraps at 65535 -> 0.

Behaviour:
- Input FIFOs are first-word-fall-through: in_dout[k] is valid while !in_empty[k]; in_rden[k] pops it that cycle.
- Reset values:
  - state = S_ACC, ch = 0, wcnt = 0, acc = 0, frames_done = 0, mode_q = 0.
  - in_rden = 0, out_wren = 0, out_din = 0, busy = 0.
- mode_q captures per_ch_mode only when ch == 0 and wcnt == 0 in S_ACC. Changes to per_ch_mode mid-frame are ignored until the next frame start.
- S_ACC:
  - in_rden[ch] = !in_empty[ch]; all other in_rden bits are 0.
  - On a pop: acc <= acc + sign_extend(in_dout[ch]), modulo 2^ACC_W.
  - If wcnt < FRAME_LEN-1: wcnt++.
  - Else (last word of this channel):
    - mode_q == 1, or ch == NUM_CH-1: go to S_WRITE; acc is loaded with the final sum that same edge.
    - Otherwise: ch++, wcnt <= 0, stay in S_ACC, acc keeps running.
  - in_empty[ch] == 1: stall, no pop, no state change. Other channels' data is never touched.
- S_WRITE:
  - out_din = acc (registered); out_wren = !out_full.
  - When out_wren is high:
    - acc <= 0, wcnt <= 0, frames_done++.
    - ch <= (ch == NUM_CH-1) ? 0 : ch+1.
    - Return to S_ACC.
  - When out_full is high: hold S_WRITE with out_din stable.
- Throughput and latency:
  - One word per cycle when no stalls.
  - Result write appears exactly 1 cycle after the last pop if out_full is low.
  - No pop occurs in the S_WRITE cycle.
- busy = (state == S_WRITE) || (wcnt != 0) || (ch != 0 && mode_q == 0).
- NUM_CH == 1: ch stays 0; both modes are identical.
- Reset mid-frame: the partial sum is discarded with no write, and the next frame starts at channel 0.
- Out-of-range ch never occurs; ch uses a $clog2(NUM_CH) counter with a minimum width of 1.

Optional Feature:
- Macro: FRAME_ACC_SAT_EN.
- Defined:
  - Each addition saturates to the signed ACC_W range: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
  - A sticky bit sat_flag (extra output port, 1 bit) sets on any clipping.
  - sat_flag is cleared at the same edge as the write of that result and is valid alongside out_wren.
- Undefined: wrap-around addition and no sat_flag port.

Decomposition:
- Package frame_acc_pkg:
  - state enum {S_ACC, S_WRITE}.
  - FRAMES_DONE_W = 16.
  - Function sext(DATA_W -> ACC_W).
- One sub-module, frame_acc_datapath: the channel mux, sign extension, accumulator register and optional saturation.
- The FSM and counters stay in the top.

Test Plan:
- NUM_CH=2, FRAME_LEN=4, mode 0; ch0 = {1,2,3,4}, ch1 = {10,20,30,40} -> single write out_din = 110, frames_done = 1, in_rden pops ch0 four times then ch1 four times.
- Same data, mode 1 -> two writes: 10 then 100, frames_done = 2.
- Mode 0, ch1 empty for 5 cycles after ch0 completes -> no ch0 pops during the stall, result still 110, busy = 1 throughout.
- out_full held high 3 cycles at the write -> out_wren low 3 cycles, out_din = 110 held, write on cycle 4, no pops meanwhile.
- rst asserted after 2 ch0 pops, then full frame {5,5,5,5},{-5,-5,-5,-5} -> result 0, no write from the aborted frame.
- DATA_W=8, ACC_W=8, FRAME_LEN=4, NUM_CH=1; inputs 100×4:
  - With FRAME_ACC_SAT_EN: out_din = 127, sat_flag = 1.
  - Without it: out_din = 400 mod 256 = 144 (-112 signed).

Source files
------------

// File: rtl/frame_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_acc_pkg
//  Description : Shared types and helpers for the frame accumulator.
//                Holds the controller state encoding, the frames-done counter
//                width and a generic sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_acc_pkg;

  typedef enum logic [0:0] {
    S_ACC   = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam int FRAMES_DONE_W = 16;

  // Widest word the sign-extension helper handles; callers zero-pad their
  // operand up to this width and keep only the low bits of the result.
  localparam int SEXT_MAX_W = 128;

  // Replicates bit [width-1] of value into every bit above it.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] value,
                                                 input int                    width);
    logic [SEXT_MAX_W-1:0] r;
    r = value;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i >= width) r[i] = value[width-1];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_acc_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : frame_acc_datapath
//  Description : Channel mux, sign extension and accumulator register.
//                Optional saturating addition with sticky clip flag when
//                FRAME_ACC_SAT_EN is defined; wrap-around addition otherwise.
//  Ports       : bus_clk, rst      - clock, synchronous active-high reset
//                ch                - channel currently being drained
//                in_dout           - packed FWFT data of all channels
//                pop               - accumulate the selected word this cycle
//                clear             - result written, restart from zero
//                acc               - accumulator value
//                sat_flag          - sticky clip flag (FRAME_ACC_SAT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_acc_datapath
  import frame_acc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int CH_W   = 1
) (
  input  logic                     bus_clk,
  input  logic                     rst,
  input  logic [CH_W-1:0]          ch,
  input  logic [NUM_CH*DATA_W-1:0] in_dout,
  input  logic                     pop,
  input  logic                     clear,
  output logic [ACC_W-1:0]         acc
`ifdef FRAME_ACC_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  logic [DATA_W-1:0]     w_word;
  logic [SEXT_MAX_W-1:0] w_ext_full;
  logic [ACC_W-1:0]      w_ext;
  logic [ACC_W-1:0]      w_next;
  logic [ACC_W-1:0]      r_acc;
  logic                  w_unused_ext;

  assign w_word     = in_dout[int'(ch)*DATA_W +: DATA_W];
  assign w_ext_full = sext({{(SEXT_MAX_W-DATA_W){1'b0}}, w_word}, DATA_W);
  assign w_ext      = w_ext_full[ACC_W-1:0];
  assign w_unused_ext = ^w_ext_full[SEXT_MAX_W-1:ACC_W];

`ifdef FRAME_ACC_SAT_EN
  // One guard bit: overflow shows up as the two top bits disagreeing, and
  // the guard bit then carries the true sign of the unclipped sum.
  logic [ACC_W:0] w_sum_wide;
  logic           w_ovf;
  logic           r_sat;

  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
  assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];

  always_comb begin
    w_next = w_sum_wide[ACC_W-1:0];
    if (w_ovf) begin
      w_next = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge bus_clk) begin
    if (rst || clear) r_sat <= 1'b0;
    else if (pop && w_ovf) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign w_next = r_acc + w_ext;
`endif

  always_ff @(posedge bus_clk) begin
    if (rst)        r_acc <= '0;
    else if (clear) r_acc <= '0;
    else if (pop)   r_acc <= w_next;
  end

  assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : frame_accumulator
//  Description : Drains NUM_CH FWFT host FIFOs round-robin, FRAME_LEN words
//                per channel, summing signed words. Emits one sum per channel
//                frame (per_ch_mode=1) or one combined sum (per_ch_mode=0)
//                into the return FIFO. Define FRAME_ACC_SAT_EN for saturating
//                accumulation and the sat_flag output.
//  Ports       : bus_clk, rst      - clock, synchronous active-high reset
//                in_empty/in_rden  - per-channel FIFO empty / pop (one-hot)
//                in_dout           - channel k at [k*DATA_W +: DATA_W]
//                out_full/out_wren - return FIFO full / write strobe
//                out_din           - sum being written
//                per_ch_mode       - sampled at each frame start
//                busy              - frame in progress or awaiting write
//                frames_done       - results written (wrapping)
//                sat_flag          - clip seen in this result (SAT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_accumulator
  import frame_acc_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 128,
  parameter int ACC_W     = 48
) (
  input  logic                     bus_clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_empty,
  output logic [NUM_CH-1:0]        in_rden,
  input  logic [NUM_CH*DATA_W-1:0] in_dout,
  input  logic                     out_full,
  output logic                     out_wren,
  output logic [ACC_W-1:0]         out_din,
  input  logic                     per_ch_mode,
  output logic                     busy,
  output logic [FRAMES_DONE_W-1:0] frames_done
`ifdef FRAME_ACC_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int c_ch_w   = (NUM_CH > 1)    ? $clog2(NUM_CH)    : 1;
  localparam int c_wcnt_w = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [c_ch_w-1:0]   c_ch_last   = c_ch_w'(NUM_CH - 1);
  localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(FRAME_LEN - 1);

  state_t                   r_state;
  logic [c_ch_w-1:0]        r_ch;
  logic [c_wcnt_w-1:0]      r_wcnt;
  logic [FRAMES_DONE_W-1:0] r_frames_done;
  logic                     r_mode_q;

  logic w_cur_empty;
  logic w_pop;
  logic w_wr;
  logic w_frame_start;
  logic w_mode;

  always_comb begin
    w_cur_empty = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(r_ch) == k) w_cur_empty = in_empty[k];
    end
  end

  assign w_pop         = (r_state == S_ACC) && !w_cur_empty;
  assign w_wr          = (r_state == S_WRITE) && !out_full;
  assign w_frame_start = (r_state == S_ACC) && (r_ch == '0) && (r_wcnt == '0);

  // The mode register only loads at frame start, so on that very cycle the
  // live input is the value in force (matters when FRAME_LEN == 1).
  assign w_mode = w_frame_start ? per_ch_mode : r_mode_q;

  always_comb begin
    in_rden = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_rden[k] = w_pop && (int'(r_ch) == k);
    end
  end

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      r_state       <= S_ACC;
      r_ch          <= '0;
      r_wcnt        <= '0;
      r_frames_done <= '0;
      r_mode_q      <= 1'b0;
    end else begin
      if (w_frame_start) r_mode_q <= per_ch_mode;
      case (r_state)
        S_ACC: begin
          if (w_pop) begin
            if (r_wcnt != c_wcnt_last) begin
              r_wcnt <= r_wcnt + 1'b1;
            end else if (w_mode || (r_ch == c_ch_last)) begin
              r_state <= S_WRITE;
            end else begin
              r_ch   <= r_ch + 1'b1;
              r_wcnt <= '0;
            end
          end
        end
        S_WRITE: begin
          if (!out_full) begin
            r_wcnt        <= '0;
            r_frames_done <= r_frames_done + 1'b1;
            r_ch          <= (r_ch == c_ch_last) ? '0 : r_ch + 1'b1;
            r_state       <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  frame_acc_datapath #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CH_W   (c_ch_w)
  ) u_datapath (
    .bus_clk  (bus_clk),
    .rst      (rst),
    .ch       (r_ch),
    .in_dout  (in_dout),
    .pop      (w_pop),
    .clear    (w_wr),
    .acc      (out_din)
`ifdef FRAME_ACC_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  assign out_wren    = w_wr;
  assign frames_done = r_frames_done;
  assign busy        = (r_state == S_WRITE) || (r_wcnt != '0) ||
                       ((r_ch != '0) && !r_mode_q);

endmodule
`default_nettype wire

// File: tb/tb_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_accumulator
//  Description : Directed self-checking bench for frame_accumulator. A main
//                instance (2 ch, 32-bit, 4-word frames, 48-bit sums) fed by
//                small FIFO models, plus a 1-channel 8-bit instance for the
//                wrap/saturation case (FRAME_ACC_SAT_EN selects expectations).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_accumulator;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 4;
  localparam int ACC_W     = 48;

  logic bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  logic                     rst;
  logic [NUM_CH-1:0]        in_empty;
  logic [NUM_CH-1:0]        in_rden;
  logic [NUM_CH*DATA_W-1:0] in_dout;
  logic                     out_full;
  logic                     out_wren;
  logic [ACC_W-1:0]         out_din;
  logic                     per_ch_mode;
  logic                     busy;
  logic [15:0]              frames_done;

  logic        s_in_empty;
  logic        s_in_rden;
  logic [7:0]  s_in_dout;
  logic        s_out_wren;
  logic [7:0]  s_out_din;
  logic        s_busy;
  logic [15:0] s_frames_done;

`ifdef FRAME_ACC_SAT_EN
  logic sat_flag;
  logic s_sat_flag;
`endif

  frame_accumulator #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)
  ) dut (
    .bus_clk(bus_clk), .rst(rst), .in_empty(in_empty), .in_rden(in_rden),
    .in_dout(in_dout), .out_full(out_full), .out_wren(out_wren), .out_din(out_din),
    .per_ch_mode(per_ch_mode), .busy(busy), .frames_done(frames_done)
`ifdef FRAME_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  frame_accumulator #(
    .NUM_CH(1), .DATA_W(8), .FRAME_LEN(4), .ACC_W(8)
  ) dut_small (
    .bus_clk(bus_clk), .rst(rst), .in_empty(s_in_empty), .in_rden(s_in_rden),
    .in_dout(s_in_dout), .out_full(1'b0), .out_wren(s_out_wren), .out_din(s_out_din),
    .per_ch_mode(1'b0), .busy(s_busy), .frames_done(s_frames_done)
`ifdef FRAME_ACC_SAT_EN
    , .sat_flag(s_sat_flag)
`endif
  );

  // FIFO models: contents/count written by the stimulus, read pointer by the clock.
  logic [DATA_W-1:0] fifo_mem [NUM_CH][64];
  int                fifo_cnt [NUM_CH];
  int                fifo_rd  [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic              flush;

  always_comb begin
    in_empty = '0;
    in_dout  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_empty[k] = stall[k] || (fifo_rd[k] >= fifo_cnt[k]);
      in_dout[k*DATA_W +: DATA_W] = fifo_mem[k][fifo_rd[k] % 64];
    end
  end

  always @(posedge bus_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (flush)          fifo_rd[k] <= fifo_cnt[k];
      else if (in_rden[k]) fifo_rd[k] <= fifo_rd[k] + 1;
    end
  end

  // Activity log
  int               cyc = 0;
  int               pop_n = 0;
  int               wr_n = 0;
  int               s_pop_n = 0;
  int               last_pop_cyc = 0;
  int               wr_cyc = 0;
  int               multi_pop = 0;
  int               pop_ch [256];
  logic [ACC_W-1:0] wr_val [64];

  always @(posedge bus_clk) begin
    cyc <= cyc + 1;
    if (in_rden == 2'b11) multi_pop <= multi_pop + 1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_rden[k]) begin
        pop_ch[pop_n % 256] <= k;
        pop_n               <= pop_n + 1;
        last_pop_cyc        <= cyc;
      end
    end
    if (out_wren) begin
      wr_val[wr_n % 64] <= out_din;
      wr_n              <= wr_n + 1;
      wr_cyc            <= cyc;
    end
    if (s_in_rden) s_pop_n <= s_pop_n + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic push(input int k, input logic [DATA_W-1:0] v);
    fifo_mem[k][fifo_cnt[k] % 64] = v;
    fifo_cnt[k]++;
  endtask

  task automatic load_frame();
    push(0, 32'd1);  push(0, 32'd2);  push(0, 32'd3);  push(0, 32'd4);
    push(1, 32'd10); push(1, 32'd20); push(1, 32'd30); push(1, 32'd40);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b1;
    repeat (2) @(negedge bus_clk);
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int i;
    i = 0;
    while (wr_n < target && i < budget) begin
      @(negedge bus_clk);
      i++;
    end
    if (wr_n < target) check("write_timeout", 64'(wr_n), 64'(target));
  endtask

  task automatic wait_pops(input int target, input int budget);
    int i;
    i = 0;
    while (pop_n < target && i < budget) begin
      @(negedge bus_clk);
      i++;
    end
    if (pop_n < target) check("pop_timeout", 64'(pop_n), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base_pop, base_wr, lp, bad_a, bad_b, bad_c;
    logic [7:0] pat;

    rst = 1'b1; flush = 1'b1; stall = '0; out_full = 1'b0; per_ch_mode = 1'b0;
    s_in_empty = 1'b1; s_in_dout = 8'd100;
    repeat (3) @(negedge bus_clk);
    rst = 1'b0; flush = 1'b0;
    @(negedge bus_clk);

    // Reset state
    check("rst_rden",   64'(in_rden), 64'd0);
    check("rst_wren",   64'(out_wren), 64'd0);
    check("rst_din",    64'(out_din), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_frames", 64'(frames_done), 64'd0);

    // Combined mode: 10 + 100 = 110, ch0 four pops then ch1 four pops
    base_pop = pop_n; base_wr = wr_n;
    load_frame();
    wait_writes(base_wr + 1, 50);
    check("t1_sum", 64'(wr_val[base_wr % 64]), 64'd110);
    check("t1_latency", 64'(wr_cyc - last_pop_cyc), 64'd1);
    check("t1_pops", 64'(pop_n - base_pop), 64'd8);
    pat = '0;
    for (int i = 0; i < 8; i++) pat[i] = (pop_ch[(base_pop + i) % 256] == 1);
    check("t1_order", 64'(pat), 64'hF0);
    check("t1_frames", 64'(frames_done), 64'd1);
    @(negedge bus_clk);
    check("t1_idle_busy", 64'(busy), 64'd0);
`ifdef FRAME_ACC_SAT_EN
    check("t1_no_sat", 64'(sat_flag), 64'd0);
`endif

    // Per-channel mode: 10 then 100
    do_reset();
    per_ch_mode = 1'b1;
    base_wr = wr_n;
    load_frame();
    wait_writes(base_wr + 2, 60);
    check("t2_sum_ch0", 64'(wr_val[base_wr % 64]), 64'd10);
    check("t2_sum_ch1", 64'(wr_val[(base_wr + 1) % 64]), 64'd100);
    check("t2_frames", 64'(frames_done), 64'd2);

    // ch1 stalled for 5 cycles after ch0 completes
    do_reset();
    per_ch_mode = 1'b0;
    stall[1] = 1'b1;
    base_pop = pop_n; base_wr = wr_n;
    load_frame();
    wait_pops(base_pop + 4, 30);
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_rden != '0) bad_a++;
      if (!busy) bad_b++;
      @(negedge bus_clk);
    end
    check("t3_stall_pops", 64'(bad_a), 64'd0);
    check("t3_stall_busy", 64'(bad_b), 64'd0);
    stall[1] = 1'b0;
    wait_writes(base_wr + 1, 30);
    check("t3_sum", 64'(wr_val[base_wr % 64]), 64'd110);

    // Return FIFO full for 3 cycles at the write; next frame data waiting
    do_reset();
    out_full = 1'b1;
    base_pop = pop_n; base_wr = wr_n;
    load_frame();
    for (int i = 0; i < 4; i++) push(0, 32'd7);
    wait_pops(base_pop + 8, 30);
    lp = last_pop_cyc;
    bad_a = 0; bad_b = 0; bad_c = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_wren) bad_a++;
      if (out_din != 48'd110) bad_b++;
      if (in_rden != '0) bad_c++;
      @(negedge bus_clk);
    end
    check("t4_hold_wren", 64'(bad_a), 64'd0);
    check("t4_hold_din", 64'(bad_b), 64'd0);
    check("t4_hold_pops", 64'(bad_c), 64'd0);
    out_full = 1'b0;
    wait_writes(base_wr + 1, 5);
    check("t4_sum", 64'(wr_val[base_wr % 64]), 64'd110);
    check("t4_write_cycle", 64'(wr_cyc - lp), 64'd4);

    // Reset after two ch0 pops discards the partial frame
    do_reset();
    base_pop = pop_n; base_wr = wr_n;
    for (int i = 0; i < 4; i++) push(0, 32'd9);
    wait_pops(base_pop + 2, 20);
    stall[0] = 1'b1;
    rst = 1'b1; flush = 1'b1;
    repeat (2) @(negedge bus_clk);
    rst = 1'b0; flush = 1'b0; stall[0] = 1'b0;
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_nowrite", 64'(wr_n - base_wr), 64'd0);
    for (int i = 0; i < 4; i++) push(0, 32'd5);
    for (int i = 0; i < 4; i++) push(1, 32'hFFFF_FFFB);
    wait_writes(base_wr + 1, 40);
    check("t5_sum", 64'(wr_val[base_wr % 64]), 64'd0);
    check("t5_frames", 64'(frames_done), 64'd1);

    // Single 8-bit channel, 100 x 4
    s_in_empty = 1'b0;
    repeat (4) @(negedge bus_clk);
    s_in_empty = 1'b1;
    check("t6_wren", 64'(s_out_wren), 64'd1);
`ifdef FRAME_ACC_SAT_EN
    check("t6_sum_sat", 64'(s_out_din), 64'd127);
    check("t6_sat_flag", 64'(s_sat_flag), 64'd1);
`else
    check("t6_sum_wrap", 64'(s_out_din), 64'd144);
`endif
    @(negedge bus_clk);
    check("t6_frames", 64'(s_frames_done), 64'd1);
    check("t6_pops", 64'(s_pop_n), 64'd4);
    check("t6_idle_busy", 64'(s_busy), 64'd0);
`ifdef FRAME_ACC_SAT_EN
    check("t6_sat_clear", 64'(s_sat_flag), 64'd0);
`endif

    check("rden_onehot", 64'(multi_pop), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
